// File: rtl/name_stream_packer.sv
// name_stream_packer
//   Packs an upstream ASCII byte stream into 32-bit status/data words for an HPS PIO
//   in_port. Each published word is held stable until the HPS acknowledges it by
//   toggling ack_toggle.
//
//   stream_word layout: [31] valid, [30] last, [29:28] byte count (1..3), [27:24] seq,
//   [23:0] bytes (byte0 in [7:0]); unused byte lanes are zero.
//
// Parameters
//   FLUSH_CYCLES  idle cycles with a partial word pending before it is published anyway
//                 (0 disables flushing)
//   ACK_SYNC      1 = two-flop synchronizer on ack_toggle, 0 = use ack_toggle directly
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   in_data      ASCII byte from upstream
//   in_valid     in_data valid
//   in_last      in_data is the final byte of a name
//   in_ready     a byte is accepted this cycle when in_valid is also high
//   ack_toggle   HPS acknowledge; every level change acknowledges one word
//   stream_word  word driven to the PIO in_port
//   ack_err      sticky: an ack edge arrived while no word was published
module name_stream_packer #(
    parameter int unsigned FLUSH_CYCLES = 0,
    parameter int unsigned ACK_SYNC     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        ack_toggle,
    output logic [31:0] stream_word,
    output logic        ack_err
);

    localparam int unsigned TimerW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [0:0] {
        StFill,
        StHold
    } state_e;

    state_e             state_q, state_d;
    logic [23:0]        stage_q, stage_d;
    logic [1:0]         count_q, count_d;
    logic [3:0]         seq_q, seq_d;
    logic [31:0]        word_q, word_d;
    logic               ack_err_q, ack_err_d;
    logic               ack_seen_q;
    logic [TimerW-1:0]  timer_q, timer_d;

    logic               ack_s;
    logic               ack_edge;
    logic               accept;
    logic [23:0]        staged;
    logic [1:0]         count_inc;
    logic               publish;
    logic               pub_last;
    logic [1:0]         pub_count;
    logic [23:0]        pub_bytes;

    // Acknowledge input conditioning
    if (ACK_SYNC != 0) begin : g_ack_sync
        logic [1:0] sync_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= 2'b00;
            end else begin
                sync_q <= {sync_q[0], ack_toggle};
            end
        end
        assign ack_s = sync_q[1];
    end else begin : g_ack_direct
        assign ack_s = ack_toggle;
    end

    assign ack_edge = ack_s ^ ack_seen_q;

    // in_ready is forced low while reset is asserted, even though the reset state is FILL.
    assign in_ready    = reset_n & (state_q == StFill);
    assign accept      = in_valid & (state_q == StFill);
    assign stream_word = word_q;
    assign ack_err     = ack_err_q;

    // Staging register with the incoming byte dropped into lane count_q.
    always_comb begin
        staged = stage_q;
        unique case (count_q)
            2'd0:    staged[7:0]   = in_data;
            2'd1:    staged[15:8]  = in_data;
            default: staged[23:16] = in_data;
        endcase
    end

    assign count_inc = count_q + 2'd1;

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        count_d   = count_q;
        seq_d     = seq_q;
        word_d    = word_q;
        ack_err_d = ack_err_q;
        timer_d   = timer_q;
        publish   = 1'b0;
        pub_last  = 1'b0;
        pub_count = count_q;
        pub_bytes = stage_q;

        unique case (state_q)
            StFill: begin
                // An edge here has no word to release; it is consumed and flagged.
                if (ack_edge) begin
                    ack_err_d = 1'b1;
                end
                if (accept) begin
                    timer_d = '0;
                    if (in_last || (count_q == 2'd2)) begin
                        publish   = 1'b1;
                        pub_last  = in_last;
                        pub_count = count_inc;
                        pub_bytes = staged;
                    end else begin
                        stage_d = staged;
                        count_d = count_inc;
                    end
                end else if ((FLUSH_CYCLES != 0) && (count_q != 2'd0)) begin
                    if (timer_q == TimerW'(FLUSH_CYCLES - 1)) begin
                        publish = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (ack_edge) begin
                    word_d[31] = 1'b0;
                    state_d    = StFill;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase

        if (publish) begin
            word_d  = {1'b1, pub_last, pub_count, seq_q, pub_bytes};
            seq_d   = seq_q + 4'd1;
            stage_d = '0;
            count_d = 2'd0;
            timer_d = '0;
            state_d = StHold;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StFill;
            stage_q    <= '0;
            count_q    <= 2'd0;
            seq_q      <= 4'd0;
            word_q     <= '0;
            ack_err_q  <= 1'b0;
            ack_seen_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            word_q     <= word_d;
            ack_err_q  <= ack_err_d;
            // Tracking ack_s every cycle equals updating it only on an edge.
            ack_seen_q <= ack_s;
            timer_q    <= timer_d;
        end
    end

endmodule
